// File: rtl/bmp_load_ctrl.sv
// bmp_load_ctrl: pulls an IMG_W x IMG_H bitmap from the pixel PIO handshake into the frame buffer.
// Optional BMP_KEY_TRANSPARENT_EN: pixels equal to KEY_COLOR are acked and skipped, not written.
module bmp_load_ctrl #(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int STRIDE = 640,
  parameter int ADDR_W = 19,
  parameter logic [23:0] KEY_COLOR = 24'hFF00FF
) (
  input  logic              Clk,
  input  logic              Reset_h,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [23:0]       pix_in,
  input  logic              pix_valid,
  output logic              pix_ack,
  output logic              fb_we,
  output logic [ADDR_W-1:0] fb_addr,
  output logic [23:0]       fb_data,
  input  logic              fb_grant,
  output logic              busy,
  output logic              done
);
  localparam int XW = IMG_W > 1 ? $clog2(IMG_W) : 1;
  localparam int YW = IMG_H > 1 ? $clog2(IMG_H) : 1;
  typedef enum logic [2:0] {IDLE, WAIT_V, WRITE, ACK, DONE} state_t;
  state_t state;
  logic [XW-1:0] x, x_nx;
  logic [YW-1:0] y, y_nx;
  logic [ADDR_W-1:0] row_addr, row_nx, cur_addr, cur_nx;
  logic last, last_nx, eol;
  assign fb_addr = cur_addr;
  // next raster position, applied when a pixel is consumed
  always_comb begin
    eol = x == XW'(IMG_W - 1);
    x_nx = eol ? '0 : x + 1'b1;
    y_nx = eol ? y + 1'b1 : y;
    row_nx = eol ? row_addr + ADDR_W'(STRIDE) : row_addr;
    cur_nx = eol ? row_nx : cur_addr + 1'b1;
    last_nx = eol && y == YW'(IMG_H - 1);
  end
  always_ff @(posedge Clk or posedge Reset_h) begin
    if (Reset_h) begin
      state <= IDLE;
      {x, y, row_addr, cur_addr, last} <= '0;
      {fb_we, fb_data, pix_ack, busy, done} <= '0;
    end else if (abort && state != IDLE) begin
      state <= IDLE;
      {fb_we, pix_ack, busy, done} <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          row_addr <= base_addr;
          cur_addr <= base_addr;
          x <= '0;
          y <= '0;
          busy <= 1'b1;
          state <= WAIT_V;
        end
        WAIT_V: if (pix_valid) begin
          fb_data <= pix_in;
`ifdef BMP_KEY_TRANSPARENT_EN
          if (pix_in == KEY_COLOR) begin
            {x, y, row_addr, cur_addr, last} <= {x_nx, y_nx, row_nx, cur_nx, last_nx};
            pix_ack <= 1'b1;
            state <= ACK;
          end else begin
            fb_we <= 1'b1;
            state <= WRITE;
          end
`else
          fb_we <= 1'b1;
          state <= WRITE;
`endif
        end
        WRITE: if (fb_grant) begin
          {x, y, row_addr, cur_addr, last} <= {x_nx, y_nx, row_nx, cur_nx, last_nx};
          fb_we <= 1'b0;
          pix_ack <= 1'b1;
          state <= ACK;
        end
        ACK: if (!pix_valid) begin
          pix_ack <= 1'b0;
          done <= last;
          state <= last ? DONE : WAIT_V;
        end
        DONE: begin
          done <= 1'b0;
          busy <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_bmp_load_ctrl.sv
// tb_bmp_load_ctrl: scoreboard bench for bmp_load_ctrl with a 2x2 image.
module tb_bmp_load_ctrl;
  localparam int W = 2, H = 2, S = 640, AW = 19;
  localparam logic [23:0] KEY = 24'hFF00FF;
  logic Clk = 0, Reset_h = 0, start = 0, abort = 0, pix_valid = 0, fb_grant = 1;
  logic [AW-1:0] base_addr = '0, fb_addr;
  logic [23:0] pix_in = '0, fb_data;
  logic pix_ack, fb_we, busy, done;
  int total = 0, bad = 0, writes = 0, dones = 0;
  logic [AW+23:0] sb[$];

  bmp_load_ctrl #(.IMG_W(W), .IMG_H(H), .STRIDE(S), .ADDR_W(AW), .KEY_COLOR(KEY)) dut (
    .Clk(Clk), .Reset_h(Reset_h), .start(start), .abort(abort), .base_addr(base_addr),
    .pix_in(pix_in), .pix_valid(pix_valid), .pix_ack(pix_ack), .fb_we(fb_we),
    .fb_addr(fb_addr), .fb_data(fb_data), .fb_grant(fb_grant), .busy(busy), .done(done));

  always #5 Clk = ~Clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // a write completes at the coming edge when requested, granted and not aborted
  always @(negedge Clk) if (!Reset_h) begin
    if (fb_we && fb_grant && !abort) begin
      writes++;
      check("sb_has_entry", 64'(sb.size() != 0), 1);
      if (sb.size() != 0) check("write", 64'({fb_addr, fb_data}), 64'(sb.pop_front()));
    end
    if (done) dones++;
  end

  task automatic tick();
    @(posedge Clk);
    #2;
  endtask

  task automatic start_load(input logic [AW-1:0] b);
    base_addr = b;
    start = 1;
    tick();
    start = 0;
  endtask

  task automatic wait_ack(input logic lvl, input string tag);
    int n = 0;
    while (pix_ack !== lvl && n < 200) begin
      tick();
      n++;
    end
    check(tag, 64'(pix_ack), 64'(lvl));
  endtask

  task automatic send(input logic [23:0] p);
    pix_in = p;
    pix_valid = 1;
    wait_ack(1, "ack_hi");
    pix_valid = 0;
    wait_ack(0, "ack_lo");
  endtask

  task automatic expect_px(input logic [AW-1:0] b, input int i, input logic [23:0] p, inout int n);
    logic [AW-1:0] a;
    a = b + AW'((i / W) * S + (i % W));
`ifdef BMP_KEY_TRANSPARENT_EN
    if (p == KEY) return;
`endif
    sb.push_back({a, p});
    n++;
  endtask

  task automatic wait_done(input int d0, input int w0, input int nw);
    int n = 0;
    while (dones == d0 && n < 20) begin
      tick();
      n++;
    end
    tick();
    check("done_once", 64'(dones - d0), 1);
    check("busy_low", 64'(busy), 0);
    check("write_cnt", 64'(writes - w0), 64'(nw));
    check("sb_drained", 64'(sb.size()), 0);
  endtask

  task automatic load(input logic [AW-1:0] b, input logic [95:0] px);
    int d0, w0, nw;
    d0 = dones;
    w0 = writes;
    nw = 0;
    for (int i = 0; i < 4; i++) expect_px(b, i, px[i*24 +: 24], nw);
    start_load(b);
    for (int i = 0; i < 4; i++) send(px[i*24 +: 24]);
    wait_done(d0, w0, nw);
  endtask

  task automatic outs_zero(input string tag);
    check(tag, 64'({pix_ack, fb_we, fb_addr, fb_data, busy, done}), 0);
  endtask

  initial begin
    int d0, w0, n;
    #1 Reset_h = 1;
    #1 outs_zero("reset");
    tick();
    Reset_h = 0;
    tick();
    outs_zero("idle");

    load(19'd1000, {24'hDDDDDD, 24'hCCCCCC, 24'hBBBBBB, 24'hAAAAAA});

    // grant stall followed by slow software on the same pixel
    d0 = dones;
    w0 = writes;
    sb.push_back({19'd2000, 24'h5A5A5A});
    start_load(19'd2000);
    check("busy_start", 64'(busy), 1);
    fb_grant = 0;
    pix_in = 24'h5A5A5A;
    pix_valid = 1;
    n = 0;
    while (!fb_we && n < 50) begin tick(); n++; end
    check("we_rise", 64'(fb_we), 1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check("stall_hold", 64'({fb_we, fb_addr, fb_data, pix_ack}), 64'({1'b1, 19'd2000, 24'h5A5A5A, 1'b0}));
    end
    check("stall_nowrite", 64'(writes - w0), 0);
    fb_grant = 1;
    wait_ack(1, "stall_ack");
    check("stall_one_write", 64'(writes - w0), 1);
    for (int i = 0; i < 20; i++) begin
      tick();
      check("slow_ack_hold", 64'({pix_ack, 32'(writes - w0)}), 64'({1'b1, 32'd1}));
    end
    pix_valid = 0;
    wait_ack(0, "slow_ack_lo");
    n = 1;
    expect_px(19'd2000, 1, 24'h111111, n);
    expect_px(19'd2000, 2, 24'h222222, n);
    expect_px(19'd2000, 3, 24'h333333, n);
    send(24'h111111);
    send(24'h222222);
    send(24'h333333);
    wait_done(d0, w0, n);

    // abort during WRITE of the third pixel with grant in the same cycle
    d0 = dones;
    w0 = writes;
    sb.push_back({19'd3000, 24'h000001});
    sb.push_back({19'd3001, 24'h000002});
    start_load(19'd3000);
    send(24'h000001);
    send(24'h000002);
    fb_grant = 0;
    pix_in = 24'h000003;
    pix_valid = 1;
    n = 0;
    while (!fb_we && n < 50) begin tick(); n++; end
    check("abort_we_rise", 64'(fb_we), 1);
    abort = 1;
    fb_grant = 1;
    tick();
    abort = 0;
    pix_valid = 0;
    check("abort_idle", 64'({busy, fb_we, pix_ack}), 0);
    tick();
    tick();
    check("abort_nodone", 64'(dones - d0), 0);
    check("abort_writes", 64'(writes - w0), 2);
    check("abort_sb", 64'(sb.size()), 0);
    load(19'd4000, {24'h444444, 24'h333333, 24'h222222, 24'h111111});

    // asynchronous reset while in ACK
    w0 = writes;
    sb.push_back({19'd5000, 24'h777777});
    start_load(19'd5000);
    pix_in = 24'h777777;
    pix_valid = 1;
    wait_ack(1, "rst_ack");
    #3 Reset_h = 1;
    #1 outs_zero("rst_async");
    pix_valid = 0;
    tick();
    Reset_h = 0;
    check("rst_writes", 64'(writes - w0), 1);
    tick();
    load(19'd6000, {24'h0F0F0F, 24'h0E0E0E, 24'h0D0D0D, 24'h0C0C0C});

    // key colour pixels: skipped when transparency is enabled, written otherwise
    load(19'd0, {24'h654321, KEY, 24'h123456, KEY});
    load(19'h7FFFF, {24'h000004, 24'h000003, 24'h000002, 24'h000001});

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
